// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - GPIO register offsets, CTRL bit indices and address decode helper
package gpio_pkg;

  localparam int GPIO_W_DEFAULT = 32;

  localparam logic [31:0] GPIO_OFS_IN    = 32'h00;
  localparam logic [31:0] GPIO_OFS_OUT   = 32'h04;
  localparam logic [31:0] GPIO_OFS_OE    = 32'h08;
  localparam logic [31:0] GPIO_OFS_INTE  = 32'h0C;
  localparam logic [31:0] GPIO_OFS_PTRIG = 32'h10;
  localparam logic [31:0] GPIO_OFS_CTRL  = 32'h14;
  localparam logic [31:0] GPIO_OFS_INTS  = 32'h18;

  localparam int CTRL_INTE_BIT = 0;
  localparam int CTRL_INTS_BIT = 1;

  typedef enum logic [2:0] {
    SEL_IN,
    SEL_OUT,
    SEL_OE,
    SEL_INTE,
    SEL_PTRIG,
    SEL_CTRL,
    SEL_INTS,
    SEL_NONE
  } reg_sel_e;

  // Byte lanes are ignored; anything outside the 7 word offsets decodes to SEL_NONE.
  function automatic reg_sel_e decode_sel(input logic [31:0] addr);
    logic [31:0] w_word;
    w_word = addr & ~32'h3;
    case (w_word)
      GPIO_OFS_IN:    decode_sel = SEL_IN;
      GPIO_OFS_OUT:   decode_sel = SEL_OUT;
      GPIO_OFS_OE:    decode_sel = SEL_OE;
      GPIO_OFS_INTE:  decode_sel = SEL_INTE;
      GPIO_OFS_PTRIG: decode_sel = SEL_PTRIG;
      GPIO_OFS_CTRL:  decode_sel = SEL_CTRL;
      GPIO_OFS_INTS:  decode_sel = SEL_INTS;
      default:        decode_sel = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad synchronizer, previous-value flop and per-bit edge event
module gpio_sync_edge
  import gpio_pkg::*;
#(
  parameter int GPIO_W = GPIO_W_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [GPIO_W-1:0] i_pad,
  input  logic [GPIO_W-1:0] i_ptrig,
  output logic [GPIO_W-1:0] o_in,
  output logic [GPIO_W-1:0] o_event
);

  logic [GPIO_W-1:0] r_s1;
  logic [GPIO_W-1:0] r_s2;
  logic [GPIO_W-1:0] r_prev;
  logic [GPIO_W-1:0] w_rise;
  logic [GPIO_W-1:0] w_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= i_pad;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_rise  = r_s2 & ~r_prev;
  assign w_fall  = ~r_s2 & r_prev;
  assign o_in    = r_s2;
  assign o_event = (i_ptrig & w_rise) | (~i_ptrig & w_fall);

endmodule

// File: rtl/gpio_register_core.sv
// rtl/gpio_register_core.sv - GPIO register file with edge interrupts and W1C status
module gpio_register_core
  import gpio_pkg::*;
#(
  parameter int GPIO_W = GPIO_W_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              gpio_we,
  input  logic [31:0]       gpio_addr,
  input  logic [31:0]       gpio_data_in,
  output logic [31:0]       gpio_data_out,
  output logic              gpio_inta_o,
  input  logic [GPIO_W-1:0] ext_pad_i,
  output logic [GPIO_W-1:0] ext_pad_o,
  output logic [GPIO_W-1:0] ext_padoe_o
);

  logic [GPIO_W-1:0] r_out;
  logic [GPIO_W-1:0] r_oe;
  logic [GPIO_W-1:0] r_inte;
  logic [GPIO_W-1:0] r_ptrig;
  logic [GPIO_W-1:0] r_ints;
  logic              r_ctrl_inte;

  logic [GPIO_W-1:0] w_in;
  logic [GPIO_W-1:0] w_event;
  logic [GPIO_W-1:0] w_wdata;
  logic [GPIO_W-1:0] w_ints_clr;
  logic              w_ints_any;
  reg_sel_e          w_sel;
  logic [31:0]       w_rdata;

  function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
    zext = '0;
    zext[GPIO_W-1:0] = v;
  endfunction

  gpio_sync_edge #(
    .GPIO_W (GPIO_W)
  ) u_sync_edge (
    .i_clk   (sys_clk),
    .i_rst   (sys_rst),
    .i_pad   (ext_pad_i),
    .i_ptrig (r_ptrig),
    .o_in    (w_in),
    .o_event (w_event)
  );

  assign w_sel      = decode_sel(gpio_addr);
  assign w_wdata    = gpio_data_in[GPIO_W-1:0];
  assign w_ints_clr = (gpio_we && w_sel == SEL_INTS) ? w_wdata : '0;
  assign w_ints_any = |r_ints;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_out       <= '0;
      r_oe        <= '0;
      r_inte      <= '0;
      r_ptrig     <= '0;
      r_ints      <= '0;
      r_ctrl_inte <= 1'b0;
    end else begin
      if (gpio_we) begin
        case (w_sel)
          SEL_OUT:   r_out       <= w_wdata;
          SEL_OE:    r_oe        <= w_wdata;
          SEL_INTE:  r_inte      <= w_wdata;
          SEL_PTRIG: r_ptrig     <= w_wdata;
          SEL_CTRL:  r_ctrl_inte <= gpio_data_in[CTRL_INTE_BIT];
          default:   ;
        endcase
      end
      // Clear first, then OR in new events so a same-cycle set wins over W1C.
      r_ints <= (r_ints & ~w_ints_clr) | (w_event & r_inte);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      SEL_IN:    w_rdata = zext(w_in);
      SEL_OUT:   w_rdata = zext(r_out);
      SEL_OE:    w_rdata = zext(r_oe);
      SEL_INTE:  w_rdata = zext(r_inte);
      SEL_PTRIG: w_rdata = zext(r_ptrig);
      SEL_CTRL: begin
        w_rdata[CTRL_INTE_BIT] = r_ctrl_inte;
        w_rdata[CTRL_INTS_BIT] = w_ints_any;
      end
      SEL_INTS:  w_rdata = zext(r_ints);
      default:   w_rdata = '0;
    endcase
  end

  assign gpio_data_out = w_rdata;
  assign gpio_inta_o   = r_ctrl_inte & w_ints_any;
  assign ext_pad_o     = r_out;
  assign ext_padoe_o   = r_oe;

endmodule

// File: tb/tb_gpio_register_core.sv
// tb/tb_gpio_register_core.sv - directed table-driven bench for gpio_register_core
module tb_gpio_register_core;

  logic        sys_clk;
  logic        sys_rst;
  logic        gpio_we;
  logic [31:0] gpio_addr;
  logic [31:0] gpio_data_in;
  logic [31:0] gpio_data_out;
  logic        gpio_inta_o;
  logic [31:0] ext_pad_i;
  logic [31:0] ext_pad_o;
  logic [31:0] ext_padoe_o;

  int total;
  int bad;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic [31:0] exp_pad_o;
    logic [31:0] exp_oe;
  } vec_t;

  vec_t vecs [16];

  gpio_register_core #(.GPIO_W(32)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .gpio_we       (gpio_we),
    .gpio_addr     (gpio_addr),
    .gpio_data_in  (gpio_data_in),
    .gpio_data_out (gpio_data_out),
    .gpio_inta_o   (gpio_inta_o),
    .ext_pad_i     (ext_pad_i),
    .ext_pad_o     (ext_pad_o),
    .ext_padoe_o   (ext_padoe_o)
  );

  initial sys_clk = 1'b0;
  always #10 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    gpio_we      = 1'b1;
    gpio_addr    = addr;
    gpio_data_in = data;
    tick();
    gpio_we      = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    gpio_addr = addr;
    #1;
    chk(name, gpio_data_out, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    total        = 0;
    bad          = 0;
    sys_rst      = 1'b1;
    gpio_we      = 1'b0;
    gpio_addr    = '0;
    gpio_data_in = '0;
    ext_pad_i    = '0;

    vecs[0]  = '{1'b1, 32'h04, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000};
    vecs[1]  = '{1'b1, 32'h08, 32'h0000FFFF, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[2]  = '{1'b1, 32'h1C, 32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[3]  = '{1'b1, 32'h00, 32'h12345678, 32'h00000000, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[4]  = '{1'b1, 32'h24, 32'hFFFFFFFF, 32'h00000000, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[5]  = '{1'b1, 32'h0C, 32'h0000000F, 32'h0000000F, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[6]  = '{1'b1, 32'h10, 32'h00000005, 32'h00000005, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[7]  = '{1'b1, 32'h14, 32'hFFFFFFFF, 32'h00000001, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[8]  = '{1'b1, 32'h14, 32'h00000000, 32'h00000000, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[9]  = '{1'b1, 32'h07, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0000FFFF};
    vecs[10] = '{1'b1, 32'h18, 32'hFFFFFFFF, 32'h00000000, 32'h0F0F0F0F, 32'h0000FFFF};
    vecs[11] = '{1'b1, 32'h0C, 32'h00000000, 32'h00000000, 32'h0F0F0F0F, 32'h0000FFFF};
    vecs[12] = '{1'b1, 32'h10, 32'h00000000, 32'h00000000, 32'h0F0F0F0F, 32'h0000FFFF};
    vecs[13] = '{1'b0, 32'h04, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0000FFFF};
    vecs[14] = '{1'b1, 32'h04, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0000FFFF};
    vecs[15] = '{1'b0, 32'h08, 32'h00000000, 32'h0000FFFF, 32'hA5A5A5A5, 32'h0000FFFF};

    // Reset for two cycles, then everything reads zero.
    tick();
    tick();
    chk("rst_pad_o", ext_pad_o, 32'h0);
    chk("rst_oe", ext_padoe_o, 32'h0);
    chk("rst_inta", {31'd0, gpio_inta_o}, 32'h0);
    for (int a = 0; a <= 'h18; a += 4) begin
      rd_chk($sformatf("rst_rd_%02h", a), a, 32'h0);
    end
    sys_rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].we) wr(vecs[i].addr, vecs[i].data);
      else tick();
      rd_chk($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_rd);
      chk($sformatf("vec%0d_pad_o", i), ext_pad_o, vecs[i].exp_pad_o);
      chk($sformatf("vec%0d_oe", i), ext_padoe_o, vecs[i].exp_oe);
    end

    // Rising edge on pad 0: INTS sets two edges after the edge that samples it.
    wr(32'h0C, 32'h1);
    wr(32'h10, 32'h1);
    wr(32'h14, 32'h1);
    ext_pad_i[0] = 1'b1;
    tick();
    rd_chk("rise_ints_k", 32'h18, 32'h0);
    tick();
    rd_chk("rise_ints_k1", 32'h18, 32'h0);
    chk("rise_inta_k1", {31'd0, gpio_inta_o}, 32'h0);
    tick();
    rd_chk("rise_ints_k2", 32'h18, 32'h1);
    chk("rise_inta_k2", {31'd0, gpio_inta_o}, 32'h1);
    rd_chk("rise_ctrl", 32'h14, 32'h3);
    rd_chk("rise_in", 32'h00, 32'h1);

    wr(32'h18, 32'h1);
    rd_chk("w1c0_ints", 32'h18, 32'h0);
    chk("w1c0_inta", {31'd0, gpio_inta_o}, 32'h0);

    // Falling edge on pad 3, then W1C behaviour.
    ext_pad_i[3] = 1'b1;
    repeat (4) tick();
    wr(32'h0C, 32'h9);
    ext_pad_i[3] = 1'b0;
    tick();
    tick();
    rd_chk("fall_ints_k1", 32'h18, 32'h0);
    tick();
    rd_chk("fall_ints_k2", 32'h18, 32'h8);
    chk("fall_inta", {31'd0, gpio_inta_o}, 32'h1);
    wr(32'h18, 32'h1);
    rd_chk("w1c_zero_bits_kept", 32'h18, 32'h8);
    wr(32'h0C, 32'h1);
    rd_chk("inte_clear_keeps_ints", 32'h18, 32'h8);
    wr(32'h18, 32'h8);
    rd_chk("w1c3_ints", 32'h18, 32'h0);
    chk("w1c3_inta", {31'd0, gpio_inta_o}, 32'h0);

    // W1C on bit 0 lands on the same edge as a new rising event on bit 0.
    ext_pad_i[0] = 1'b0;
    repeat (4) tick();
    rd_chk("coll_pre_ints", 32'h18, 32'h0);
    ext_pad_i[0] = 1'b1;
    tick();
    tick();
    wr(32'h18, 32'h1);
    rd_chk("coll_set_wins", 32'h18, 32'h1);
    chk("coll_inta", {31'd0, gpio_inta_o}, 32'h1);
    wr(32'h18, 32'h1);
    rd_chk("coll_after_clr", 32'h18, 32'h0);

    // Reset mid-operation with a concurrent OUT write.
    ext_pad_i = '0;
    repeat (4) tick();
    wr(32'h0C, 32'hF);
    wr(32'h10, 32'hF);
    wr(32'h04, 32'h12);
    ext_pad_i = 32'hF;
    repeat (3) tick();
    rd_chk("mid_ints_pre", 32'h18, 32'hF);
    chk("mid_pad_o_pre", ext_pad_o, 32'h12);
    sys_rst      = 1'b1;
    gpio_we      = 1'b1;
    gpio_addr    = 32'h04;
    gpio_data_in = 32'hFF;
    tick();
    sys_rst = 1'b0;
    gpio_we = 1'b0;
    chk("mid_pad_o", ext_pad_o, 32'h0);
    chk("mid_oe", ext_padoe_o, 32'h0);
    chk("mid_inta", {31'd0, gpio_inta_o}, 32'h0);
    for (int a = 4; a <= 'h18; a += 4) begin
      rd_chk($sformatf("mid_rd_%02h", a), a, 32'h0);
    end
    repeat (4) tick();
    rd_chk("post_rst_ints", 32'h18, 32'h0);
    rd_chk("post_rst_in", 32'h00, 32'hF);
    chk("post_rst_inta", {31'd0, gpio_inta_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
